// File: rtl/fifo_pkt_framer.sv
// Read-side packet framer: drains an async FIFO and emits header/payload/XOR-trailer
// packets on a valid/ready stream, with flush aborting the packet in progress.
module fifo_pkt_framer #(
  parameter int         DATASIZE = 32,
  parameter int         PKT_LEN  = 8,
  parameter logic [7:0] HDR_TAG  = 8'hA5
) (
  input  logic                clk_out,
  input  logic                rst,
  input  logic                empty,
  input  logic [DATASIZE-1:0] fifo_data,
  input  logic                flush,
  output logic                remove,
  output logic [DATASIZE-1:0] pkt_data,
  output logic                pkt_valid,
  input  logic                pkt_ready,
  output logic                pkt_sop,
  output logic                pkt_eop,
  output logic                pkt_err
);

  localparam int            CW  = 17;
  localparam logic [CW-1:0] LEN = CW'(PKT_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    TRAIL   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // p1: word returning from the FIFO plus the two-entry skid buffer
  logic                vld_p1, vld_p1_d;
  logic [DATASIZE-1:0] skid0_p1, skid0_p1_d;
  logic [DATASIZE-1:0] skid1_p1, skid1_p1_d;
  logic [1:0]          skid_cnt_p1, skid_cnt_p1_d;

  // p2: presented output beat
  logic [DATASIZE-1:0] data_p2, data_p2_d;
  logic                vld_p2, vld_p2_d;
  logic                sop_p2, sop_p2_d;
  logic                eop_p2, eop_p2_d;
  logic                err_p2, err_p2_d;

  logic [CW-1:0]       req_cnt, req_cnt_d;
  logic [CW-1:0]       sent_cnt, sent_cnt_d;
  logic [DATASIZE-1:0] csum, csum_d;
  logic [7:0]          seq, seq_d;
  logic                abort_pend, abort_pend_d;

  logic xfer;
  logic out_free;
  logic abort;

  function automatic logic [DATASIZE-1:0] make_header(input logic [7:0] s);
    return {HDR_TAG, s, 16'(PKT_LEN)};
  endfunction

  assign xfer     = vld_p2 & pkt_ready;
  assign out_free = ~vld_p2 | pkt_ready;
  assign abort    = flush | abort_pend;

  assign pkt_data  = data_p2;
  assign pkt_valid = vld_p2;
  assign pkt_sop   = sop_p2;
  assign pkt_eop   = eop_p2;
  assign pkt_err   = err_p2;

  always_comb begin
    state_d       = state_q;
    vld_p1_d      = 1'b0;
    skid0_p1_d    = skid0_p1;
    skid1_p1_d    = skid1_p1;
    skid_cnt_p1_d = skid_cnt_p1;
    data_p2_d     = data_p2;
    vld_p2_d      = vld_p2;
    sop_p2_d      = sop_p2;
    eop_p2_d      = eop_p2;
    err_p2_d      = err_p2;
    req_cnt_d     = req_cnt;
    sent_cnt_d    = sent_cnt;
    csum_d        = csum;
    seq_d         = seq;
    abort_pend_d  = abort_pend;
    remove        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty && !flush) begin
          state_d       = HDR;
          data_p2_d     = make_header(seq);
          vld_p2_d      = 1'b1;
          sop_p2_d      = 1'b1;
          eop_p2_d      = 1'b0;
          err_p2_d      = 1'b0;
          csum_d        = '0;
          req_cnt_d     = '0;
          sent_cnt_d    = '0;
          skid_cnt_p1_d = 2'd0;
          abort_pend_d  = 1'b0;
        end
      end

      HDR: begin
        if (flush) abort_pend_d = 1'b1;
        if (xfer) begin
          state_d  = PAYLOAD;
          vld_p2_d = 1'b0;
          sop_p2_d = 1'b0;
        end
      end

      PAYLOAD: begin
        if (xfer) begin
          csum_d     = csum ^ data_p2;
          sent_cnt_d = sent_cnt + CW'(1);
        end

        if (abort) begin
          // Buffered and in-flight words are dropped; only the presented beat survives.
          abort_pend_d  = 1'b1;
          skid_cnt_p1_d = 2'd0;
          if (out_free) begin
            state_d   = TRAIL;
            data_p2_d = csum_d;
            vld_p2_d  = 1'b1;
            sop_p2_d  = 1'b0;
            eop_p2_d  = 1'b1;
            err_p2_d  = 1'b1;
          end
        end else begin
          remove = !empty && (req_cnt < LEN) &&
                   (({1'b0, skid_cnt_p1} + {2'b00, vld_p1}) < 3'd2);
          if (remove) req_cnt_d = req_cnt + CW'(1);
          vld_p1_d = remove;

          if (xfer && (sent_cnt + CW'(1) == LEN)) begin
            state_d   = TRAIL;
            data_p2_d = csum_d;
            vld_p2_d  = 1'b1;
            sop_p2_d  = 1'b0;
            eop_p2_d  = 1'b1;
            err_p2_d  = 1'b0;
          end else if (out_free) begin
            // Skid head is older than the returning word, so it goes out first.
            sop_p2_d = 1'b0;
            eop_p2_d = 1'b0;
            err_p2_d = 1'b0;
            if (skid_cnt_p1 != 2'd0) begin
              data_p2_d     = skid0_p1;
              vld_p2_d      = 1'b1;
              skid0_p1_d    = skid1_p1;
              skid_cnt_p1_d = skid_cnt_p1 - 2'd1;
              if (vld_p1) begin
                if (skid_cnt_p1 == 2'd1) skid0_p1_d = fifo_data;
                else                     skid1_p1_d = fifo_data;
                skid_cnt_p1_d = skid_cnt_p1;
              end
            end else if (vld_p1) begin
              data_p2_d = fifo_data;
              vld_p2_d  = 1'b1;
            end else begin
              vld_p2_d = 1'b0;
            end
          end else if (vld_p1) begin
            if (skid_cnt_p1 == 2'd0) skid0_p1_d = fifo_data;
            else                     skid1_p1_d = fifo_data;
            skid_cnt_p1_d = skid_cnt_p1 + 2'd1;
          end
        end
      end

      TRAIL: begin
        if (xfer) begin
          state_d      = IDLE;
          vld_p2_d     = 1'b0;
          eop_p2_d     = 1'b0;
          err_p2_d     = 1'b0;
          seq_d        = seq + 8'd1;
          abort_pend_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      vld_p1      <= 1'b0;
      skid_cnt_p1 <= 2'd0;
      data_p2     <= '0;
      vld_p2      <= 1'b0;
      sop_p2      <= 1'b0;
      eop_p2      <= 1'b0;
      err_p2      <= 1'b0;
      req_cnt     <= '0;
      sent_cnt    <= '0;
      csum        <= '0;
      seq         <= 8'd0;
      abort_pend  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vld_p1      <= vld_p1_d;
      skid_cnt_p1 <= skid_cnt_p1_d;
      data_p2     <= data_p2_d;
      vld_p2      <= vld_p2_d;
      sop_p2      <= sop_p2_d;
      eop_p2      <= eop_p2_d;
      err_p2      <= err_p2_d;
      req_cnt     <= req_cnt_d;
      sent_cnt    <= sent_cnt_d;
      csum        <= csum_d;
      seq         <= seq_d;
      abort_pend  <= abort_pend_d;
    end
  end

  always_ff @(posedge clk_out) begin
    skid0_p1 <= skid0_p1_d;
    skid1_p1 <= skid1_p1_d;
  end

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Scoreboard bench for fifo_pkt_framer: a behavioural FIFO feeds the DUT, expected beats
// are queued at stimulus time and a monitor process pops and compares each transfer.
module tb_fifo_pkt_framer;
  localparam int PKT_LEN = 8;

  logic        clk_out = 1'b0;
  logic        rst;
  logic        empty;
  logic [31:0] fifo_data;
  logic        flush;
  logic        remove;
  logic [31:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        pkt_sop;
  logic        pkt_eop;
  logic        pkt_err;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic        err;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] fmem [0:4095];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          checks;
  int          failures;
  int          viol_empty;
  int          viol_abort;
  int          rdy_mode;
  logic        abort_win;
  logic [7:0]  tb_seq;

  always #5 clk_out = ~clk_out;

  fifo_pkt_framer #(.DATASIZE(32), .PKT_LEN(PKT_LEN), .HDR_TAG(8'hA5)) dut (
    .clk_out   (clk_out),
    .rst       (rst),
    .empty     (empty),
    .fifo_data (fifo_data),
    .flush     (flush),
    .remove    (remove),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_sop   (pkt_sop),
    .pkt_eop   (pkt_eop),
    .pkt_err   (pkt_err)
  );

  // Behavioural FIFO: dataOut valid the cycle after a remove; flush/reset empty it.
  assign empty = (rd_ptr == wr_ptr);

  always @(posedge clk_out) begin
    if (!rst || flush) begin
      rd_ptr <= wr_ptr;
    end else if (remove && !empty) begin
      fifo_data <= fmem[rd_ptr % 4096];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic s, input logic e, input logic r);
    beat_t b;
    b.data = d;
    b.sop  = s;
    b.eop  = e;
    b.err  = r;
    exp_q.push_back(b);
  endtask

  task automatic exp_pkt(input int first, input int nsent, input logic err);
    logic [31:0] x;
    x = 32'd0;
    exp_beat({8'hA5, tb_seq, 16'(PKT_LEN)}, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < nsent; j++) begin
      exp_beat(32'(first + j), 1'b0, 1'b0, 1'b0);
      x = x ^ 32'(first + j);
    end
    exp_beat(x, 1'b0, 1'b1, err);
    tb_seq = tb_seq + 8'd1;
  endtask

  task automatic fifo_push(input int first, input int n);
    for (int j = 0; j < n; j++) begin
      fmem[wr_ptr % 4096] = 32'(first + j);
      wr_ptr++;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk_out); #1;
      pkt_ready = (rdy_mode == 1) ? ~pkt_ready : 1'b1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic monitor();
    beat_t       e;
    logic        stall;
    logic [34:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk_out);
      if (!rst) begin
        stall = 1'b0;
      end else begin
        if (remove && empty) viol_empty++;
        if (abort_win && remove) viol_abort++;
        if (stall) begin
          checks++;
          if (!pkt_valid || {pkt_data, pkt_sop, pkt_eop, pkt_err} != held) begin
            failures++;
            $display("FAIL stall_hold: got v=%b %h/%b%b%b, required v=1 %h/%b%b%b",
                     pkt_valid, pkt_data, pkt_sop, pkt_eop, pkt_err,
                     held[34:3], held[2], held[1], held[0]);
          end
        end
        if (pkt_valid && pkt_ready) begin
          stall = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL beat_unexpected: got %h sop=%b eop=%b err=%b, required no beat",
                     pkt_data, pkt_sop, pkt_eop, pkt_err);
          end else begin
            e = exp_q.pop_front();
            if ({pkt_data, pkt_sop, pkt_eop, pkt_err} !== e) begin
              failures++;
              $display("FAIL beat: got %h sop=%b eop=%b err=%b, required %h sop=%b eop=%b err=%b",
                       pkt_data, pkt_sop, pkt_eop, pkt_err, e.data, e.sop, e.eop, e.err);
            end
            if (e.sop) abort_win = 1'b0;
          end
        end else if (pkt_valid) begin
          stall = 1'b1;
          held  = {pkt_data, pkt_sop, pkt_eop, pkt_err};
        end else begin
          stall = 1'b0;
        end
      end
    end
  endtask

  initial begin
    logic found;
    checks     = 0;
    failures   = 0;
    viol_empty = 0;
    viol_abort = 0;
    rdy_mode   = 0;
    abort_win  = 1'b0;
    tb_seq     = 8'd0;
    rst        = 1'b0;
    flush      = 1'b0;
    pkt_ready  = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk_out);
    #1;
    chk("rst_remove", {31'd0, remove}, 32'd0);
    chk("rst_valid", {31'd0, pkt_valid}, 32'd0);
    chk("rst_data", pkt_data, 32'd0);
    chk("rst_sop_eop_err", {29'd0, pkt_sop, pkt_eop, pkt_err}, 32'd0);
    rst = 1'b1;

    // Back-to-back packet, ready held high
    rdy_mode = 0;
    exp_pkt(1, 8, 1'b0);
    fifo_push(1, 8);
    wait_drain("t1");

    // Same stream, ready toggling
    rdy_mode  = 1;
    pkt_ready = 1'b1;
    exp_pkt(1, 8, 1'b0);
    fifo_push(1, 8);
    wait_drain("t2");

    // FIFO runs dry mid-packet
    rdy_mode  = 0;
    pkt_ready = 1'b1;
    exp_pkt(1, 8, 1'b0);
    fifo_push(1, 3);
    repeat (15) begin @(posedge clk_out); #1; end
    chk("t3_gap_valid", {31'd0, pkt_valid}, 32'd0);
    repeat (5) begin @(posedge clk_out); #1; end
    fifo_push(4, 5);
    wait_drain("t3");

    // Flush coinciding with the 4th payload transfer
    exp_pkt(1, 4, 1'b1);
    fifo_push(1, 8);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk_out); #1;
      if (pkt_valid && !pkt_sop && !pkt_eop && pkt_data == 32'd4) begin
        found     = 1'b1;
        flush     = 1'b1;
        abort_win = 1'b1;
        @(posedge clk_out); #1;
        flush = 1'b0;
      end
    end
    chk("t4_flush_point", {31'd0, found}, 32'd1);
    exp_pkt(17, 8, 1'b0);
    fifo_push(17, 8);
    wait_drain("t4");
    chk("t4_remove_in_abort", 32'(viol_abort), 32'd0);

    // Asynchronous reset while a payload beat is presented
    exp_pkt(1, 8, 1'b0);
    fifo_push(1, 8);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk_out); #1;
      if (pkt_valid && !pkt_sop && !pkt_eop) found = 1'b1;
    end
    chk("t5_payload_seen", {31'd0, found}, 32'd1);
    rst = 1'b0;
    #1;
    chk("t5_remove", {31'd0, remove}, 32'd0);
    chk("t5_valid", {31'd0, pkt_valid}, 32'd0);
    chk("t5_data", pkt_data, 32'd0);
    chk("t5_sop_eop_err", {29'd0, pkt_sop, pkt_eop, pkt_err}, 32'd0);
    exp_q.delete();
    tb_seq = 8'd0;
    repeat (2) @(posedge clk_out);
    #1;
    rst = 1'b1;
    exp_pkt(1, 8, 1'b0);
    fifo_push(1, 8);
    wait_drain("t5");

    // 257 packets from a fresh reset: sequence wraps FF -> 00
    rst = 1'b0;
    repeat (2) @(posedge clk_out);
    #1;
    rst    = 1'b1;
    tb_seq = 8'd0;
    for (int k = 0; k < 257; k++) begin
      exp_pkt(k * 256 + 1, 8, 1'b0);
      fifo_push(k * 256 + 1, 8);
      wait_drain("t6");
    end

    chk("no_read_when_empty", 32'(viol_empty), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
